pcm_mem_seq: RTL and testbench
==============================

PCM_MEM_SEQ -- requirements
Module: pcm_mem_seq

Interface
REQ-001 Parameter RD_LAT, default 1, memory read latency in clocks from address-issue cycle to valid readdata; legal 1..4.
REQ-002 Parameter MEM_WORDS, default 2048, number of 16-bit words in the PCM on-chip memory.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  1  arbiter presents a granted request.
REQ-006 req_ready  out  1  block can accept a request.
REQ-007 req_write  in  1  1 = write, 0 = read.
REQ-008 req_addr  in  20  CPU word address.
REQ-009 req_wdata  in  16  write data.
REQ-010 req_id  in  2  requesting CPU index 0..3.
REQ-011 rsp_valid  out  1  response available.
REQ-012 rsp_ready  in  1  arbiter accepts response.
REQ-013 rsp_rdata  out  16  read data; 0 for writes and errors.
REQ-014 rsp_id  out  2  req_id of the completed request.
REQ-015 rsp_err  out  1  request address out of range.
REQ-016 pcm_mem_mm_address  out  11 / pcm_mem_mm_chipselect  out  1 / pcm_mem_mm_clken  out  1 / pcm_mem_mm_write  out  1 / pcm_mem_mm_writedata  out  16 / pcm_mem_mm_byteenable  out  2 / pcm_mem_mm_readdata  in  16: memory port.
REQ-017 access_count  out  16  number of memory accesses issued, saturating.

Function
REQ-018 FSM states IDLE, ISSUE, RDWAIT, RESP; a 3-bit latency counter shall time RDWAIT.
REQ-019 req_ready shall be 1 only in IDLE; accept = req_valid & req_ready.
REQ-020 On accept, write, addr, wdata, id shall be latched into internal registers; later changes on req_* have no effect.
REQ-021 Accept with req_addr >= MEM_WORDS: IDLE->RESP, rsp_err=1, rsp_rdata=0, no memory access, access_count unchanged.
REQ-022 Accept with in-range address: IDLE->ISSUE.
REQ-023 ISSUE (exactly one cycle): chipselect=1, clken=1, address=latched addr[10:0], write=latched write, writedata=latched wdata.
REQ-024 ISSUE with write: next state RESP, rsp_rdata=0, rsp_err=0.
REQ-025 ISSUE with read: next state RDWAIT for exactly RD_LAT cycles with chipselect=1, clken=1, write=0, address held.
REQ-026 readdata shall be captured at the clock edge ending the last RDWAIT cycle, then RESP.
REQ-027 Read latency: accept edge at cycle 0 -> rsp_valid high from cycle RD_LAT+2; write/error: rsp_valid from cycle 2 / cycle 1.
REQ-028 In IDLE and RESP: chipselect=0, clken=0, write=0; address/writedata hold last latched value.
REQ-029 pcm_mem_mm_byteenable shall be constant 2'b11.
REQ-030 RESP: rsp_valid=1, rsp_rdata/rsp_id/rsp_err stable until rsp_valid & rsp_ready; then IDLE next cycle.
REQ-031 No request shall be accepted in the cycle the response handshake completes (req_ready=0 in RESP).
REQ-032 access_count shall increment by 1 on each entry to ISSUE and saturate at 16'hFFFF.
REQ-033 Outside RESP, rsp_valid=0; rsp_ready while rsp_valid=0 is ignored.

Reset
REQ-034 reset_n low shall asynchronously force IDLE, latency counter 0, rsp_valid=0, rsp_rdata=0, rsp_id=0, rsp_err=0, chipselect=0, clken=0, write=0, address=0, writedata=0, access_count=0.
REQ-035 Reset during ISSUE, RDWAIT or RESP shall drop the in-flight request with no response; req_ready=1 on the first clock after reset_n rises.

Verification
REQ-036 Write addr 0x00005, data 0xBEEF, id 2 -> one ISSUE cycle with address 5, write=1, writedata 0xBEEF; rsp_valid cycle 2, rsp_id 2, rsp_err 0, access_count 1.
REQ-037 RD_LAT=1, read addr 5, memory returns 0xBEEF -> chipselect/clken high cycles 1-2, rsp_valid cycle 3, rsp_rdata 0xBEEF, write never asserted.
REQ-038 Read addr 0x00800 (=MEM_WORDS) -> rsp_valid cycle 1, rsp_err 1, rsp_rdata 0, chipselect never asserted, access_count unchanged.
REQ-039 rsp_ready held low 5 cycles with req_valid high -> rsp_* stable, req_ready 0 throughout; second request accepted only after handshake returns to IDLE.
REQ-040 reset_n low during RDWAIT -> rsp_valid stays 0, all memory outputs 0 immediately, req_ready 1 one cycle after release.
REQ-041 RD_LAT=4 read and 65536 back-to-back writes -> rsp_valid cycle 6 for the read; access_count stops at 0xFFFF.

Source files
------------

// File: rtl/pcm_mem_seq.sv
// ============================================================================
// pcm_mem_seq : sequences one arbitrated CPU request onto the PCM on-chip RAM
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pcm_mem_seq #(
  parameter int RD_LAT    = 1,
  parameter int MEM_WORDS = 2048
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [19:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic [1:0]  req_id,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic [1:0]  rsp_id,
  output logic        rsp_err,
  output logic [10:0] pcm_mem_mm_address,
  output logic        pcm_mem_mm_chipselect,
  output logic        pcm_mem_mm_clken,
  output logic        pcm_mem_mm_write,
  output logic [15:0] pcm_mem_mm_writedata,
  output logic [1:0]  pcm_mem_mm_byteenable,
  input  logic [15:0] pcm_mem_mm_readdata,
  output logic [15:0] access_count
);

  localparam logic [20:0] c_mem_words = 21'(MEM_WORDS);
  localparam logic [2:0]  c_lat_init  = 3'(RD_LAT - 1);

  generate
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
      $error("pcm_mem_seq: RD_LAT must be in 1..4");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_RDWAIT = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t      r_state;
  logic [2:0]  r_lat;
  logic        r_write;
  logic [10:0] r_addr;
  logic [15:0] r_wdata;
  logic [1:0]  r_id;
  logic        r_rsp_valid;
  logic [15:0] r_rsp_rdata;
  logic [1:0]  r_rsp_id;
  logic        r_rsp_err;
  logic        r_cs;
  logic        r_clken;
  logic        r_mm_write;
  logic [15:0] r_count;

  logic w_accept;
  logic w_in_range;

  assign req_ready  = (r_state == S_IDLE);
  assign w_accept   = req_valid & req_ready;
  assign w_in_range = ({1'b0, req_addr} < c_mem_words);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_lat       <= 3'd0;
      r_write     <= 1'b0;
      r_addr      <= 11'd0;
      r_wdata     <= 16'd0;
      r_id        <= 2'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 16'd0;
      r_rsp_id    <= 2'd0;
      r_rsp_err   <= 1'b0;
      r_cs        <= 1'b0;
      r_clken     <= 1'b0;
      r_mm_write  <= 1'b0;
      r_count     <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_write <= req_write;
            r_addr  <= req_addr[10:0];
            r_wdata <= req_wdata;
            r_id    <= req_id;
            if (!w_in_range) begin
              // Out-of-range requests answer directly without touching memory
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= 16'd0;
              r_rsp_id    <= req_id;
            end else begin
              r_state    <= S_ISSUE;
              r_cs       <= 1'b1;
              r_clken    <= 1'b1;
              r_mm_write <= req_write;
              if (r_count != 16'hFFFF) begin
                r_count <= r_count + 16'd1;
              end
            end
          end
        end
        S_ISSUE: begin
          r_mm_write <= 1'b0;
          if (r_write) begin
            r_state     <= S_RESP;
            r_cs        <= 1'b0;
            r_clken     <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 16'd0;
            r_rsp_id    <= r_id;
          end else begin
            r_state <= S_RDWAIT;
            r_lat   <= c_lat_init;
          end
        end
        S_RDWAIT: begin
          if (r_lat == 3'd0) begin
            r_state     <= S_RESP;
            r_cs        <= 1'b0;
            r_clken     <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= pcm_mem_mm_readdata;
            r_rsp_id    <= r_id;
          end else begin
            r_lat <= r_lat - 3'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid             = r_rsp_valid;
  assign rsp_rdata             = r_rsp_rdata;
  assign rsp_id                = r_rsp_id;
  assign rsp_err               = r_rsp_err;
  assign pcm_mem_mm_address    = r_addr;
  assign pcm_mem_mm_chipselect = r_cs;
  assign pcm_mem_mm_clken      = r_clken;
  assign pcm_mem_mm_write      = r_mm_write;
  assign pcm_mem_mm_writedata  = r_wdata;
  assign pcm_mem_mm_byteenable = 2'b11;
  assign access_count          = r_count;

endmodule

`default_nettype wire

// File: tb/tb_pcm_mem_seq.sv
// ============================================================================
// tb_pcm_mem_seq : directed self-checking bench, RD_LAT=1 and RD_LAT=4 copies
// Revision       : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pcm_mem_seq;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Instance A: RD_LAT = 1
  logic        a_req_valid, a_req_ready, a_req_write;
  logic [19:0] a_req_addr;
  logic [15:0] a_req_wdata;
  logic [1:0]  a_req_id;
  logic        a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [15:0] a_rsp_rdata;
  logic [1:0]  a_rsp_id;
  logic [10:0] a_addr;
  logic        a_cs, a_clken, a_mmw;
  logic [15:0] a_wdata, a_rdata, a_count;
  logic [1:0]  a_be;

  // Instance B: RD_LAT = 4
  logic        b_req_valid, b_req_ready, b_req_write;
  logic [19:0] b_req_addr;
  logic [15:0] b_req_wdata;
  logic [1:0]  b_req_id;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [15:0] b_rsp_rdata;
  logic [1:0]  b_rsp_id;
  logic [10:0] b_addr;
  logic        b_cs, b_clken, b_mmw;
  logic [15:0] b_wdata, b_rdata, b_count;
  logic [1:0]  b_be;

  pcm_mem_seq #(.RD_LAT(1), .MEM_WORDS(2048)) u_dut_a (
    .clk(clk), .reset_n(reset_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_id(a_req_id),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
    .rsp_id(a_rsp_id), .rsp_err(a_rsp_err),
    .pcm_mem_mm_address(a_addr), .pcm_mem_mm_chipselect(a_cs),
    .pcm_mem_mm_clken(a_clken), .pcm_mem_mm_write(a_mmw),
    .pcm_mem_mm_writedata(a_wdata), .pcm_mem_mm_byteenable(a_be),
    .pcm_mem_mm_readdata(a_rdata), .access_count(a_count)
  );

  pcm_mem_seq #(.RD_LAT(4), .MEM_WORDS(2048)) u_dut_b (
    .clk(clk), .reset_n(reset_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_id(b_req_id),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .rsp_id(b_rsp_id), .rsp_err(b_rsp_err),
    .pcm_mem_mm_address(b_addr), .pcm_mem_mm_chipselect(b_cs),
    .pcm_mem_mm_clken(b_clken), .pcm_mem_mm_write(b_mmw),
    .pcm_mem_mm_writedata(b_wdata), .pcm_mem_mm_byteenable(b_be),
    .pcm_mem_mm_readdata(b_rdata), .access_count(b_count)
  );

  // Memory models: A returns data one clock after the address, B four clocks
  logic [15:0] mem_a [0:2047];
  logic [15:0] mem_b [0:2047];
  logic [15:0] rd_a;
  logic [15:0] pipe_b [0:3];
  int          a_cs_cycles = 0;
  int          a_wr_cycles = 0;

  assign a_rdata = rd_a;
  assign b_rdata = pipe_b[3];

  always @(posedge clk) begin
    if (a_cs) a_cs_cycles <= a_cs_cycles + 1;
    if (a_mmw) a_wr_cycles <= a_wr_cycles + 1;
    if (a_cs && a_clken) begin
      if (a_mmw) mem_a[a_addr] <= a_wdata;
      else       rd_a <= mem_a[a_addr];
    end
  end

  always @(posedge clk) begin
    if (b_cs && b_clken) begin
      if (b_mmw) mem_b[b_addr] <= b_wdata;
      else       pipe_b[0] <= mem_b[b_addr];
    end
    for (int i = 1; i < 4; i++) pipe_b[i] <= pipe_b[i-1];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One request on A from IDLE: checks response cycle, payload and memory activity
  task automatic txn_a(input logic w, input logic [19:0] addr, input logic [15:0] wd,
                       input logic [1:0] id, input logic [15:0] exp_rd, input logic exp_err,
                       input int exp_cyc, input logic [15:0] exp_cnt,
                       input int exp_cs, input int exp_wr);
    int cyc;
    int cs0;
    int wr0;
    cs0 = a_cs_cycles;
    wr0 = a_wr_cycles;
    a_req_valid = 1'b1; a_req_write = w; a_req_addr = addr; a_req_wdata = wd; a_req_id = id;
    tick;
    a_req_valid = 1'b0; a_req_write = ~w; a_req_addr = 20'hFFFFF;
    a_req_wdata = ~wd; a_req_id = ~id;
    cyc = 1;
    while (!a_rsp_valid && cyc < 20) begin
      tick;
      cyc++;
    end
    check("rsp_cycle", cyc, exp_cyc);
    check("rsp_rdata", a_rsp_rdata, exp_rd);
    check("rsp_err", a_rsp_err, exp_err);
    check("rsp_id", a_rsp_id, id);
    check("access_count", a_count, exp_cnt);
    check("cs_cycles", a_cs_cycles - cs0, exp_cs);
    check("wr_cycles", a_wr_cycles - wr0, exp_wr);
    a_rsp_ready = 1'b1;
    tick;
    a_rsp_ready = 1'b0;
    check("idle_ready", a_req_ready, 1'b1);
    check("idle_rsp_valid", a_rsp_valid, 1'b0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    for (int i = 0; i < 2048; i++) begin
      mem_a[i] = 16'h0;
      mem_b[i] = 16'h0;
    end
    mem_b[9] = 16'hC0DE;
    rd_a = 16'h0;
    for (int i = 0; i < 4; i++) pipe_b[i] = 16'h0;
    a_req_valid = 0; a_req_write = 0; a_req_addr = 0; a_req_wdata = 0; a_req_id = 0; a_rsp_ready = 0;
    b_req_valid = 0; b_req_write = 0; b_req_addr = 0; b_req_wdata = 0; b_req_id = 0; b_rsp_ready = 0;

    #12;
    check("rst_req_ready", a_req_ready, 1'b1);
    check("rst_rsp_valid", a_rsp_valid, 1'b0);
    check("rst_cs", a_cs, 1'b0);
    check("rst_address", a_addr, 11'd0);
    check("rst_count", a_count, 16'd0);
    check("byteenable", a_be, 2'b11);
    #1 reset_n = 1'b1;
    tick;
    check("post_rst_ready", a_req_ready, 1'b1);

    // Write addr 5, data BEEF, id 2 with ISSUE-cycle detail
    a_req_valid = 1; a_req_write = 1; a_req_addr = 20'h00005; a_req_wdata = 16'hBEEF; a_req_id = 2;
    tick;
    a_req_valid = 0; a_req_addr = 20'h00123; a_req_wdata = 16'h0000; a_req_id = 0; a_req_write = 0;
    check("wr_issue_cs", a_cs, 1'b1);
    check("wr_issue_clken", a_clken, 1'b1);
    check("wr_issue_write", a_mmw, 1'b1);
    check("wr_issue_addr", a_addr, 11'd5);
    check("wr_issue_wdata", a_wdata, 16'hBEEF);
    check("wr_issue_count", a_count, 16'd1);
    check("wr_issue_rsp_valid", a_rsp_valid, 1'b0);
    tick;
    check("wr_rsp_valid", a_rsp_valid, 1'b1);
    check("wr_rsp_id", a_rsp_id, 2'd2);
    check("wr_rsp_err", a_rsp_err, 1'b0);
    check("wr_rsp_rdata", a_rsp_rdata, 16'h0);
    check("wr_resp_cs", a_cs, 1'b0);
    check("wr_resp_addr_hold", a_addr, 11'd5);
    a_rsp_ready = 1;
    tick;
    a_rsp_ready = 0;
    check("wr_back_idle", a_req_ready, 1'b1);

    //      w  addr        wdata     id  exp_rd    err cyc cnt  cs wr
    txn_a(0, 20'h00005, 16'h0000, 1, 16'hBEEF, 0, 3, 16'd2, 2, 0);
    txn_a(1, 20'h007FF, 16'h1357, 0, 16'h0000, 0, 2, 16'd3, 1, 1);
    txn_a(0, 20'h007FF, 16'h0000, 3, 16'h1357, 0, 3, 16'd4, 2, 0);
    txn_a(0, 20'h00800, 16'h0000, 0, 16'h0000, 1, 1, 16'd4, 0, 0);
    txn_a(1, 20'h10005, 16'hAAAA, 2, 16'h0000, 1, 1, 16'd4, 0, 0);

    // Response back-pressure with a competing request pending
    a_req_valid = 1; a_req_write = 0; a_req_addr = 20'h00005; a_req_id = 1;
    tick;
    a_req_valid = 0;
    tick;
    tick;
    a_req_valid = 1; a_req_write = 1; a_req_addr = 20'h00007; a_req_wdata = 16'h1234; a_req_id = 3;
    for (int i = 0; i < 5; i++) begin
      check("stall_rsp_valid", a_rsp_valid, 1'b1);
      check("stall_rsp_rdata", a_rsp_rdata, 16'hBEEF);
      check("stall_rsp_id", a_rsp_id, 2'd1);
      check("stall_req_ready", a_req_ready, 1'b0);
      tick;
    end
    a_rsp_ready = 1;
    tick;
    a_rsp_ready = 0;
    check("stall_idle_ready", a_req_ready, 1'b1);
    check("stall_idle_rsp_valid", a_rsp_valid, 1'b0);
    check("stall_idle_count", a_count, 16'd5);
    tick;
    a_req_valid = 0;
    check("second_issue_write", a_mmw, 1'b1);
    check("second_issue_addr", a_addr, 11'd7);
    check("second_issue_wdata", a_wdata, 16'h1234);
    check("second_issue_count", a_count, 16'd6);
    tick;
    check("second_rsp_id", a_rsp_id, 2'd3);
    check("second_rsp_rdata", a_rsp_rdata, 16'h0);
    a_rsp_ready = 1;
    tick;
    a_rsp_ready = 0;

    // Reset while the read sits in RDWAIT
    a_req_valid = 1; a_req_write = 0; a_req_addr = 20'h00005; a_req_id = 2;
    tick;
    a_req_valid = 0;
    tick;
    check("rdwait_cs", a_cs, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    check("arst_cs", a_cs, 1'b0);
    check("arst_clken", a_clken, 1'b0);
    check("arst_write", a_mmw, 1'b0);
    check("arst_addr", a_addr, 11'd0);
    check("arst_wdata", a_wdata, 16'd0);
    check("arst_count", a_count, 16'd0);
    tick;
    check("arst_rsp_valid", a_rsp_valid, 1'b0);
    #1 reset_n = 1'b1;
    tick;
    check("arst_req_ready", a_req_ready, 1'b1);
    repeat (3) tick;
    check("arst_no_rsp", a_rsp_valid, 1'b0);

    // RD_LAT = 4 read, then 65536 back-to-back writes
    b_req_valid = 1; b_req_write = 0; b_req_addr = 20'h00009; b_req_id = 1;
    tick;
    b_req_valid = 0;
    cyc = 1;
    while (!b_rsp_valid && cyc < 20) begin
      tick;
      cyc++;
    end
    check("lat4_rsp_cycle", cyc, 6);
    check("lat4_rsp_rdata", b_rsp_rdata, 16'hC0DE);
    check("lat4_rsp_id", b_rsp_id, 2'd1);
    check("lat4_count", b_count, 16'd1);
    b_rsp_ready = 1;
    tick;
    b_req_valid = 1; b_req_write = 1; b_req_addr = 20'h00003; b_req_wdata = 16'h55AA; b_req_id = 0;
    repeat (3 * 65533) tick;
    check("sat_count_fffe", b_count, 16'hFFFE);
    repeat (3) tick;
    check("sat_count_ffff", b_count, 16'hFFFF);
    repeat (6) tick;
    check("sat_count_hold", b_count, 16'hFFFF);
    b_req_valid = 0;
    tick;
    check("sat_idle_ready", b_req_ready, 1'b1);
    check("sat_idle_rsp_valid", b_rsp_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
